// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the RV32IM pipeline hazard controller
// and the pipeline registers it drives.
package pipeline_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } ctrl_state_e;

  // One bit per pipeline control line driven by the hazard controller.
  typedef struct packed {
    logic freeze;
    logic pc_hold;
    logic if_id_hold;
    logic id_ex_hold;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_bubble;
  } hazard_ctrl_t;

  // Quiescent encoding: nothing held, nothing squashed.
  localparam hazard_ctrl_t CTRL_NOP = '0;

  // Divide down-counter width; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    return (latency > 2) ? $clog2(latency) : 1;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_div_stall_counter.sv
// Divider occupancy tracker: RUN/DIV_WAIT state plus the cycles-remaining
// down-counter, both frozen while either memory is busy.
module div_stall_counter
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        freeze,
  input  logic        start,
  output ctrl_state_e state,
  output logic        cnt_zero
);

  localparam int CW = cnt_width(DIV_LATENCY);
  // The start cycle is itself a stall cycle, so DIV_WAIT covers latency-2 more.
  localparam logic [CW-1:0] CNT_LOAD = CW'((DIV_LATENCY > 1) ? DIV_LATENCY - 2 : 0);

  logic [CW-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; the reset here is synchronous, checked inside the edge.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= '0;
    end else if (!freeze) begin
      if (start) begin
        state <= DIV_WAIT;
        cnt   <= CNT_LOAD;
      end else if (state == DIV_WAIT) begin
        if (cnt_zero) state <= RUN;
        else          cnt   <= cnt - CW'(1);
      end
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage RV32IM pipeline: priority mux
// over freeze, branch flush, divide stall and load-use, plus perf counters.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 32
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [4:0]  ID_RS1,
  input  logic [4:0]  ID_RS2,
  input  logic        ID_USES_RS1,
  input  logic        ID_USES_RS2,
  input  logic [4:0]  EX_RD,
  input  logic        EX_REG_WRITE_EN,
  input  logic        EX_MEM_READ,
  input  logic        EX_IS_DIV,
  input  logic        BRANCH_TAKEN,
  input  logic        IMEM_BUSYWAIT,
  input  logic        DMEM_BUSYWAIT,
  output logic        FREEZE,
  output logic        PC_HOLD,
  output logic        IF_ID_HOLD,
  output logic        ID_EX_HOLD,
  output logic        IF_ID_FLUSH,
  output logic        ID_EX_BUBBLE,
  output logic        EX_MEM_BUBBLE,
  output logic [31:0] STALL_CYCLES,
  output logic [31:0] FLUSH_COUNT
);

  localparam logic DIV_MULTI = (DIV_LATENCY > 1);

  ctrl_state_e  state;
  logic         cnt_zero;
  logic         mem_busy;
  logic         load_use;
  logic         div_start;
  hazard_ctrl_t ctrl;

  assign mem_busy = IMEM_BUSYWAIT | DMEM_BUSYWAIT;

  assign load_use = EX_MEM_READ & EX_REG_WRITE_EN & (EX_RD != 5'd0) &
                    ((ID_USES_RS1 & (ID_RS1 == EX_RD)) |
                     (ID_USES_RS2 & (ID_RS2 == EX_RD)));

  // A taken branch squashes the divide slot, so branch outranks divide.
  assign div_start = !RESET && !mem_busy && (state == RUN) &&
                     !BRANCH_TAKEN && EX_IS_DIV && DIV_MULTI;

  div_stall_counter #(
    .DIV_LATENCY (DIV_LATENCY)
  ) u_div_stall_counter (
    .CLK      (CLK),
    .RESET    (RESET),
    .freeze   (mem_busy),
    .start    (div_start),
    .state    (state),
    .cnt_zero (cnt_zero)
  );

  // NOTE: ctrl gets a full default before the priority chain, so no path
  // leaves a field unassigned and no latch is inferred.
  always_comb begin
    ctrl = CTRL_NOP;
    if (RESET) begin
      ctrl = CTRL_NOP;
    end else if (mem_busy) begin
      ctrl.freeze = 1'b1;
    end else if ((state == RUN) && BRANCH_TAKEN) begin
      ctrl.if_id_flush  = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end else if (div_start || ((state == DIV_WAIT) && !cnt_zero)) begin
      ctrl.pc_hold       = 1'b1;
      ctrl.if_id_hold    = 1'b1;
      ctrl.id_ex_hold    = 1'b1;
      ctrl.ex_mem_bubble = 1'b1;
    end else if ((state == RUN) && load_use) begin
      ctrl.pc_hold      = 1'b1;
      ctrl.if_id_hold   = 1'b1;
      ctrl.id_ex_bubble = 1'b1;
    end
  end

  assign FREEZE        = ctrl.freeze;
  assign PC_HOLD       = ctrl.pc_hold;
  assign IF_ID_HOLD    = ctrl.if_id_hold;
  assign ID_EX_HOLD    = ctrl.id_ex_hold;
  assign IF_ID_FLUSH   = ctrl.if_id_flush;
  assign ID_EX_BUBBLE  = ctrl.id_ex_bubble;
  assign EX_MEM_BUBBLE = ctrl.ex_mem_bubble;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      STALL_CYCLES <= '0;
      FLUSH_COUNT  <= '0;
    end else begin
      if (ctrl.freeze || ctrl.pc_hold) STALL_CYCLES <= STALL_CYCLES + 32'd1;
      if (ctrl.if_id_flush)            FLUSH_COUNT  <= FLUSH_COUNT + 32'd1;
    end
  end

endmodule
